// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: FSM state and requester identity.
package l2_arb_types;

    // Arbiter FSM: idle, or one whole-line transaction granted to a side
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } l2_arb_state_t;

    // Requester identity, used to remember who was granted last
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } l2_arb_req_t;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 cache port between the L1
// I-side miss path and the L1 D-side miss/writeback path. One whole-line
// transaction is granted at a time; address, data and response pass
// through unmodified for the granted side. Outputs are purely
// combinational from state plus inputs.
module l2_arbiter
    import l2_arb_types::*;
#(
    parameter int addr_width = 32,
    parameter int line_width = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // I-side requester
    input  logic                  i_read,
    input  logic [addr_width-1:0] i_addr,
    output logic [line_width-1:0] i_rdata,
    output logic                  i_resp,
    // D-side requester
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [addr_width-1:0] d_addr,
    input  logic [line_width-1:0] d_wdata,
    output logic [line_width-1:0] d_rdata,
    output logic                  d_resp,
    // L2 port
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [addr_width-1:0] l2_addr,
    output logic [line_width-1:0] l2_wdata,
    input  logic [line_width-1:0] l2_rdata,
    input  logic                  l2_resp
);

    l2_arb_state_t r_state;
    l2_arb_state_t w_state_next;
    l2_arb_req_t   r_last_grant;
    l2_arb_req_t   w_last_grant_next;

    logic w_i_req;
    logic w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // State and round-robin history; reset leaves last_grant = D so the
    // I-side wins the first tie. Reset mid-grant simply abandons it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Next-state and grant selection; a grant is held until l2_resp,
    // then one IDLE bubble lets the requester drop its request.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        unique case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    if (r_last_grant == REQ_I) begin
                        w_state_next      = GRANT_D;
                        w_last_grant_next = REQ_D;
                    end else begin
                        w_state_next      = GRANT_I;
                        w_last_grant_next = REQ_I;
                    end
                end else if (w_i_req) begin
                    w_state_next      = GRANT_I;
                    w_last_grant_next = REQ_I;
                end else if (w_d_req) begin
                    w_state_next      = GRANT_D;
                    w_last_grant_next = REQ_D;
                end
                // l2_resp in IDLE is stray and ignored
            end
            GRANT_I: begin
                if (l2_resp) begin
                    w_state_next = IDLE;
                end
            end
            GRANT_D: begin
                if (l2_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output mux: route the granted side to L2 and the L2 response back;
    // the non-granted side and the idle port see all zeros.
    always_comb begin
        l2_read  = 1'b0;
        l2_write = 1'b0;
        l2_addr  = '0;
        l2_wdata = '0;
        i_resp   = 1'b0;
        i_rdata  = '0;
        d_resp   = 1'b0;
        d_rdata  = '0;
        unique case (r_state)
            GRANT_I: begin
                l2_read = 1'b1;
                l2_addr = i_addr;
                i_resp  = l2_resp;
                i_rdata = l2_rdata;
            end
            GRANT_D: begin
                // A writeback takes precedence if both are asserted
                l2_write = d_write;
                l2_read  = d_read & ~d_write;
                l2_addr  = d_addr;
                l2_wdata = d_wdata;
                d_resp   = l2_resp;
                d_rdata  = l2_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
